// File: rtl/ex_stage_if.sv
// Execute-stage bus: ID/EX operands and control in, EX/MEM register out.
interface ex_stage_if #(
    parameter int BUS_WIDTH      = 32,
    parameter int ALU_FUNCT_BITS = 3,
    parameter int REGISTER       = 6
);
    logic                      ValidE, RegWrite, ALU1Src, RegDst, MemWrite, MemRead, MemtoReg;
    logic [ALU_FUNCT_BITS-1:0] ALU1Cntrl, ALU2Cntrl;
    logic [BUS_WIDTH-1:0]      Src1A, Src1B, Src1C, SignImm;
    logic [REGISTER-1:0]       Rt, Rd;
    logic                      StallE;
    logic                      ValidM, RegWriteM, MemWriteM, MemReadM, MemtoRegM;
    logic [BUS_WIDTH-1:0]      ALUOutM, WriteDataM;
    logic [REGISTER-1:0]       WriteRegM;

    modport slave (
        input  ValidE, RegWrite, ALU1Src, RegDst, MemWrite, MemRead, MemtoReg,
               ALU1Cntrl, ALU2Cntrl, Src1A, Src1B, Src1C, SignImm, Rt, Rd,
        output StallE, ValidM, RegWriteM, MemWriteM, MemReadM, MemtoRegM,
               ALUOutM, WriteDataM, WriteRegM
    );

    modport master (
        output ValidE, RegWrite, ALU1Src, RegDst, MemWrite, MemRead, MemtoReg,
               ALU1Cntrl, ALU2Cntrl, Src1A, Src1B, Src1C, SignImm, Rt, Rd,
        input  StallE, ValidM, RegWriteM, MemWriteM, MemReadM, MemtoRegM,
               ALUOutM, WriteDataM, WriteRegM
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: two chained ALUs feeding the EX/MEM register. MUL runs as a
// 4-cycle byte-serial shift-add, stalling upstream while it iterates.
module ex_stage #(
    parameter int BUS_WIDTH      = 32,
    parameter int ALU_FUNCT_BITS = 3,
    parameter int REGISTER       = 6
) (
    input  logic       CLK,
    input  logic       RST,
    ex_stage_if.slave  bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    typedef struct packed {
        logic                 valid;
        logic                 regwrite;
        logic                 memwrite;
        logic                 memread;
        logic                 memtoreg;
        logic [BUS_WIDTH-1:0] aluout;
        logic [BUS_WIDTH-1:0] wdata;
        logic [REGISTER-1:0]  wreg;
    } exmem_t;

    state_t               state_q, state_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [BUS_WIDTH-1:0] acc_q, acc_d, a_q, a_d, b_q, b_d;
    exmem_t               exmem_q, exmem_d, res;

    logic [BUS_WIDTH-1:0] opb, alu1, r1, alu2, partial, acc_sum;
    logic [7:0]           mbyte;
    logic                 stall;

    // Operand B select and first ALU
    always_comb begin
        opb = bus.ALU1Src ? bus.SignImm : bus.Src1B;
        case (bus.ALU1Cntrl)
            3'b000:  alu1 = bus.Src1A & opb;
            3'b001:  alu1 = bus.Src1A | opb;
            3'b010:  alu1 = bus.Src1A + opb;
            3'b100:  alu1 = bus.Src1A ^ opb;
            3'b101:  alu1 = bus.Src1A;
            3'b110:  alu1 = bus.Src1A - opb;
            3'b111:  alu1 = {{(BUS_WIDTH-1){1'b0}}, ($signed(bus.Src1A) < $signed(opb))};
            default: alu1 = '0; // MUL result comes from the accumulator
        endcase
    end

    // One shift-add step of the multiply; on the last step acc_sum is the product
    always_comb begin
        mbyte   = 8'(b_q >> {cnt_q, 3'b000});
        partial = (a_q * BUS_WIDTH'(mbyte)) << {cnt_q, 3'b000};
        acc_sum = acc_q + partial;
    end

    // Second ALU and the EX/MEM payload for a completing instruction
    always_comb begin
        r1 = (state_q == BUSY) ? acc_sum : alu1;
        case (bus.ALU2Cntrl)
            3'b010:  alu2 = r1 + bus.Src1C;
            3'b110:  alu2 = r1 - bus.Src1C;
            3'b100:  alu2 = r1[BUS_WIDTH-1] ? '0 : r1;
            default: alu2 = r1;
        endcase
        res.valid    = 1'b1;
        res.regwrite = bus.RegWrite;
        res.memwrite = bus.MemWrite;
        res.memread  = bus.MemRead;
        res.memtoreg = bus.MemtoReg;
        res.aluout   = alu2;
        res.wdata    = bus.Src1B;
        res.wreg     = bus.RegDst ? bus.Rd : bus.Rt;
    end

    // FSM next state; EX/MEM defaults to a bubble
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        exmem_d = '0;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.ValidE) begin
                    if (bus.ALU1Cntrl == 3'b011) begin
                        a_d     = bus.Src1A;
                        b_d     = opb;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = BUSY;
                        stall   = 1'b1;
                    end else begin
                        exmem_d = res;
                    end
                end
            end
            BUSY: begin
                acc_d = acc_sum;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    exmem_d = res;
                    state_d = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and EX/MEM registers; reset also drops any multiply in flight
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            exmem_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            exmem_q <= exmem_d;
        end
    end

    assign bus.StallE     = stall & ~RST;
    assign bus.ValidM     = exmem_q.valid;
    assign bus.RegWriteM  = exmem_q.regwrite;
    assign bus.MemWriteM  = exmem_q.memwrite;
    assign bus.MemReadM   = exmem_q.memread;
    assign bus.MemtoRegM  = exmem_q.memtoreg;
    assign bus.ALUOutM    = exmem_q.aluout;
    assign bus.WriteDataM = exmem_q.wdata;
    assign bus.WriteRegM  = exmem_q.wreg;
endmodule
